vga_timing_gen: RTL and testbench

- Produces the raster scan consumed by the sprite drawers: DrawX, DrawY, blank, plus the monitor syncs hs and vs.
- Runs on the 25 MHz pixel clock vga_clk, which also feeds every sprite ROM reader.
- Is the single source of scan position for the display path.
- blank uses the drawers' convention: 1 = visible pixel, 0 = drive black.

---
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster scan generator for the sprite display path. It produces the scan
// position (DrawX/DrawY), the visible-area flag (blank, 1 = visible), the
// active-low monitor syncs and line/frame start strobes. All outputs are
// registered and describe the same pixel, so position and strobes never skew.
//
// Optional feature macro: VGA_FRAME_COUNT_EN
//   Defined   -> adds frame_cnt, an 8-bit wrapping count of frame_start pulses.
//   Undefined -> frame_cnt port and logic are absent.
//
// Counters are 10 bits wide: H_TOT and V_TOT must not exceed 1024.
module vga_timing_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic       line_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);

    // Region bounds kept at 11 bits so an end bound of exactly 1024 still
    // compares correctly against the zero-extended 10-bit counters.
    localparam logic [10:0] H_VIS_B  = 11'(H_VIS);
    localparam logic [10:0] HS_BEG   = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_B  = 11'(V_VIS);
    localparam logic [10:0] VS_BEG   = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);

    logic [9:0]  hc_q, hc_d;
    logic [9:0]  vc_q, vc_d;
    logic [10:0] hc_w, vc_w;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_q, blank_d;
    logic        frame_q, frame_d;
    logic        line_q, line_d;

    // Next scan position and the strobes decoded from that next position, so
    // the registered strobes line up with the registered counters.
    always_comb begin
        hc_d = (hc_q == H_LAST) ? 10'd0 : hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
        end
        hc_w    = {1'b0, hc_d};
        vc_w    = {1'b0, vc_d};
        hs_d    = !((hc_w >= HS_BEG) && (hc_w < HS_END));
        vs_d    = !((vc_w >= VS_BEG) && (vc_w < VS_END));
        blank_d = (hc_w < H_VIS_B) && (vc_w < V_VIS_B);
        line_d  = (hc_d == 10'd0);
        frame_d = (hc_d == 10'd0) && (vc_d == 10'd0);
    end

    // Scan position and strobe registers; reset parks at the origin with
    // syncs inactive and all pulses low.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hc_q    <= 10'd0;
            vc_q    <= 10'd0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            frame_q <= 1'b0;
            line_q  <= 1'b0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            frame_q <= frame_d;
            line_q  <= line_d;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] fcnt_q;

    // Frame counter steps on the same edge that registers frame_start.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            fcnt_q <= 8'd0;
        end else if (frame_d) begin
            fcnt_q <= fcnt_q + 8'd1;
        end
    end

    assign frame_cnt = fcnt_q;
`endif

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign frame_start = frame_q;
    assign line_start  = line_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.
// Two instances share one clock: the default 640x480 timing for line-level
// checks, and a tiny raster (10x8 total) so whole frames fit in a short run.
// Small raster: H 6/1/2/1 -> hs low at X 7..8; V 4/1/2/1 -> vs low at Y 5..6.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst_d_n = 1'b0;
    logic       rst_s_n = 1'b0;

    logic [9:0] d_x, d_y;
    logic       d_hs, d_vs, d_blank, d_fs, d_ls;
    logic [9:0] s_x, s_y;
    logic       s_hs, s_vs, s_blank, s_fs, s_ls;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] d_fcnt, s_fcnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #20 clk = ~clk;

    vga_timing_gen dut_d (
        .vga_clk(clk), .reset_n(rst_d_n),
        .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs), .blank(d_blank),
        .frame_start(d_fs), .line_start(d_ls)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_cnt(d_fcnt)
`endif
    );

    vga_timing_gen #(
        .H_VIS(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .vga_clk(clk), .reset_n(rst_s_n),
        .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .blank(s_blank),
        .frame_start(s_fs), .line_start(s_ls)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_cnt(s_fcnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [24:0] rst_v;
        int k;
        rst_v = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        step(); step(); step();
        n_checks++;
        if ({d_x, d_y, d_hs, d_vs, d_blank, d_fs, d_ls} !== rst_v) begin
            n_fail++;
            $display("FAIL reset_init: got %h expected %h", {d_x, d_y, d_hs, d_vs, d_blank, d_fs, d_ls}, rst_v);
        end
        rst_d_n = 1'b1;
        step();
        n_checks++;
        if ({d_x, d_y, d_hs, d_vs, d_blank, d_fs, d_ls} !== {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL first_edge: X=%0d Y=%0d blank=%b fs=%b ls=%b expected X=1 Y=0 blank=1 fs=0 ls=0", d_x, d_y, d_blank, d_fs, d_ls);
        end
        k = 0;
        while (!(d_x == 10'd300 && d_y == 10'd1) && k < 2000) begin
            step(); k++;
        end
        n_checks++;
        if (!(d_x == 10'd300 && d_y == 10'd1)) begin
            n_fail++;
            $display("FAIL reach_mid: X=%0d Y=%0d expected X=300 Y=1", d_x, d_y);
        end
        rst_d_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({d_x, d_y, d_hs, d_vs, d_blank, d_fs, d_ls} !== rst_v) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got %h expected %h", i, {d_x, d_y, d_hs, d_vs, d_blank, d_fs, d_ls}, rst_v);
            end
        end
        rst_d_n = 1'b1;
        step();
        n_checks++;
        if (d_x !== 10'd1 || d_y !== 10'd0 || d_blank !== 1'b1) begin
            n_fail++;
            $display("FAIL release_mid: X=%0d Y=%0d blank=%b expected X=1 Y=0 blank=1", d_x, d_y, d_blank);
        end
    endtask

    task automatic test_line();
        int k, hs_low, hs_first, blank_low, ls_cnt;
        logic [9:0] y0;
        logic ehs, eblank;
        k = 0;
        while (!d_ls && k < 1000) begin
            step(); k++;
        end
        n_checks++;
        if (!d_ls || d_x !== 10'd0) begin
            n_fail++;
            $display("FAIL line_wait: ls=%b X=%0d expected ls=1 X=0", d_ls, d_x);
        end
        y0 = d_y;
        hs_low = 0; hs_first = -1; blank_low = 0; ls_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            ehs    = !(i >= 656 && i < 752);
            eblank = (i < 640);
            n_checks++;
            if (d_x !== 10'(i) || d_y !== y0 || d_hs !== ehs || d_blank !== eblank
                || d_ls !== (i == 0) || d_fs !== 1'b0) begin
                n_fail++;
                $display("FAIL line_px[%0d]: X=%0d Y=%0d hs=%b blank=%b ls=%b fs=%b expected X=%0d Y=%0d hs=%b blank=%b ls=%b fs=0",
                         i, d_x, d_y, d_hs, d_blank, d_ls, d_fs, i, y0, ehs, eblank, (i == 0));
            end
            if (!d_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = i;
            end
            if (!d_blank) blank_low++;
            if (d_ls) ls_cnt++;
            step();
        end
        n_checks++;
        if (hs_low != 96 || hs_first != 656) begin
            n_fail++;
            $display("FAIL hs_width: low=%0d first=%0d expected low=96 first=656", hs_low, hs_first);
        end
        n_checks++;
        if (blank_low != 160 || ls_cnt != 1) begin
            n_fail++;
            $display("FAIL line_counts: blank_low=%0d ls=%0d expected 160 and 1", blank_low, ls_cnt);
        end
        n_checks++;
        if (d_x !== 10'd0 || d_y !== y0 + 10'd1) begin
            n_fail++;
            $display("FAIL line_wrap: X=%0d Y=%0d expected X=0 Y=%0d", d_x, d_y, y0 + 10'd1);
        end
    endtask

    task automatic test_frames();
        int ex, ey, first_fs, last_fs, n_fs, vs_low, blank_low, ls_cnt;
        logic [24:0] ev;
        rst_s_n = 1'b0;
        step(); step();
        n_checks++;
        if ({s_x, s_y, s_hs, s_vs, s_blank, s_fs, s_ls} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL small_reset: got %h", {s_x, s_y, s_hs, s_vs, s_blank, s_fs, s_ls});
        end
        rst_s_n = 1'b1;
        ex = 0; ey = 0; first_fs = -1; last_fs = -1; n_fs = 0;
        vs_low = 0; blank_low = 0; ls_cnt = 0;
        for (int c = 1; c <= 245; c++) begin
            step();
            if (ex == 9) begin
                ex = 0;
                ey = (ey == 7) ? 0 : ey + 1;
            end else begin
                ex = ex + 1;
            end
            ev = {10'(ex), 10'(ey), !(ex >= 7 && ex < 9), !(ey >= 5 && ey < 7),
                  (ex < 6 && ey < 4), (ex == 0 && ey == 0), (ex == 0)};
            n_checks++;
            if ({s_x, s_y, s_hs, s_vs, s_blank, s_fs, s_ls} !== ev) begin
                n_fail++;
                $display("FAIL frame_px[%0d]: got X=%0d Y=%0d hs=%b vs=%b blank=%b fs=%b ls=%b expected %h",
                         c, s_x, s_y, s_hs, s_vs, s_blank, s_fs, s_ls, ev);
            end
            if (s_fs) begin
                n_fs++;
                if (first_fs < 0) first_fs = c;
                if (last_fs >= 0) begin
                    n_checks++;
                    if (c - last_fs != 80) begin
                        n_fail++;
                        $display("FAIL fs_period: got %0d expected 80", c - last_fs);
                    end
                end
                last_fs = c;
            end
            if (c >= 80 && c < 160) begin
                if (!s_vs) vs_low++;
                if (!s_blank) blank_low++;
                if (s_ls) ls_cnt++;
            end
        end
        n_checks++;
        if (first_fs != 80 || n_fs != 3) begin
            n_fail++;
            $display("FAIL fs_first: first=%0d count=%0d expected first=80 count=3", first_fs, n_fs);
        end
        n_checks++;
        if (vs_low != 20 || blank_low != 56 || ls_cnt != 8) begin
            n_fail++;
            $display("FAIL frame_counts: vs_low=%0d blank_low=%0d ls=%0d expected 20 56 8", vs_low, blank_low, ls_cnt);
        end
    endtask

    task automatic test_corners();
        int k;
        k = 0;
        while (!(s_x == 10'd9 && s_y == 10'd7) && k < 200) begin
            step(); k++;
        end
        n_checks++;
        if (!(s_x == 10'd9 && s_y == 10'd7)) begin
            n_fail++;
            $display("FAIL corner_wait: X=%0d Y=%0d expected X=9 Y=7", s_x, s_y);
        end
        step();
        n_checks++;
        if ({s_x, s_y, s_hs, s_vs, s_blank, s_fs, s_ls} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL corner_wrap: X=%0d Y=%0d hs=%b vs=%b blank=%b fs=%b ls=%b expected 0 0 1 1 1 1 1",
                     s_x, s_y, s_hs, s_vs, s_blank, s_fs, s_ls);
        end
        k = 0;
        while (!(s_x == 10'd5 && s_y == 10'd3) && k < 200) begin
            step(); k++;
        end
        n_checks++;
        if (!(s_x == 10'd5 && s_y == 10'd3) || s_blank !== 1'b1) begin
            n_fail++;
            $display("FAIL corner_last_vis: X=%0d Y=%0d blank=%b expected X=5 Y=3 blank=1", s_x, s_y, s_blank);
        end
        step();
        n_checks++;
        if (s_x !== 10'd6 || s_y !== 10'd3 || s_blank !== 1'b0) begin
            n_fail++;
            $display("FAIL corner_first_blank: X=%0d Y=%0d blank=%b expected X=6 Y=3 blank=0", s_x, s_y, s_blank);
        end
    endtask

    task automatic test_reset_small();
        int k;
        k = 0;
        while (!(s_x == 10'd4 && s_y == 10'd2) && k < 200) begin
            step(); k++;
        end
        rst_s_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({s_x, s_y, s_hs, s_vs, s_blank, s_fs, s_ls} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL small_reset_mid[%0d]: got %h", i, {s_x, s_y, s_hs, s_vs, s_blank, s_fs, s_ls});
            end
        end
        rst_s_n = 1'b1;
        step();
        n_checks++;
        if (s_x !== 10'd1 || s_y !== 10'd0 || s_blank !== 1'b1 || s_fs !== 1'b0) begin
            n_fail++;
            $display("FAIL small_release: X=%0d Y=%0d blank=%b fs=%b expected 1 0 1 0", s_x, s_y, s_blank, s_fs);
        end
    endtask

`ifdef VGA_FRAME_COUNT_EN
    task automatic test_frame_cnt();
        int k;
        logic [7:0] prev;
        rst_s_n = 1'b0;
        step(); step();
        n_checks++;
        if (s_fcnt !== 8'd0) begin
            n_fail++;
            $display("FAIL fcnt_reset: got %0d expected 0", s_fcnt);
        end
        rst_s_n = 1'b1;
        prev = s_fcnt;
        for (int i = 1; i <= 257; i++) begin
            k = 0;
            step();
            while (!s_fs && k < 100) begin
                prev = s_fcnt;
                step(); k++;
            end
            n_checks++;
            if (!s_fs || s_fcnt !== 8'(i) || prev !== 8'(i - 1)) begin
                n_fail++;
                $display("FAIL fcnt[%0d]: fs=%b cnt=%0d before=%0d expected cnt=%0d before=%0d",
                         i, s_fs, s_fcnt, prev, 8'(i), 8'(i - 1));
            end
            prev = s_fcnt;
        end
        step(); step(); step();
        rst_s_n = 1'b0;
        step();
        n_checks++;
        if (s_fcnt !== 8'd0) begin
            n_fail++;
            $display("FAIL fcnt_reset_mid: got %0d expected 0", s_fcnt);
        end
        rst_s_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_frames();
        test_corners();
        test_reset_small();
`ifdef VGA_FRAME_COUNT_EN
        test_frame_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
